// File: rtl/l2_mem_arbiter.sv
// Arbitrates two L2 caches onto one RAM port, evictions before reads, one command in flight; strobes hold until mem_ready.
// Define L2ARB_ROUND_ROBIN_EN to swap fixed port-0 priority for last-served round robin.
module l2_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] snooper_addr_0,
    input  logic [ADDR_W-1:0] snooper_addr_1,
    input  logic              snooper_read_valid_0,
    input  logic              snooper_read_valid_1,
    input  logic              eviction_wren_0,
    input  logic              eviction_wren_1,
    input  logic [LINE_W-1:0] evictable_cacheline_0,
    input  logic [LINE_W-1:0] evictable_cacheline_1,
    output logic [LINE_W-1:0] updated_cacheline_0,
    output logic [LINE_W-1:0] updated_cacheline_1,
    output logic              cacheline_update_valid_0,
    output logic              cacheline_update_valid_1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              overflow
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rd_vld;
    logic [1:0]        r_wr_vld;
    logic [ADDR_W-5:0] r_rd_addr [2];
    logic [ADDR_W-5:0] r_wr_addr [2];
    logic [LINE_W-1:0] r_wr_dat [2];
    logic [LINE_W-1:0] r_upd_dat [2];
    logic [1:0]        r_upd_vld;
    logic              r_owner;
    logic              r_mem_rden;
    logic              r_mem_wren;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
`ifdef L2ARB_ROUND_ROBIN_EN
    logic              r_last;
`endif

    logic [1:0]        w_rd_req;
    logic [1:0]        w_wr_req;
    logic [ADDR_W-5:0] w_req_addr [2];
    logic [LINE_W-1:0] w_req_dat [2];
    logic              w_wr_sel;
    logic              w_rd_sel;
    logic              w_wr_done;
    logic              w_rd_done;
    logic              w_unused_lsb;

    assign w_rd_req      = {snooper_read_valid_1, snooper_read_valid_0};
    assign w_wr_req      = {eviction_wren_1, eviction_wren_0};
    assign w_req_addr[0] = snooper_addr_0[ADDR_W-1:4];
    assign w_req_addr[1] = snooper_addr_1[ADDR_W-1:4];
    assign w_req_dat[0]  = evictable_cacheline_0;
    assign w_req_dat[1]  = evictable_cacheline_1;
    // Line offset bits carry no information: slots store line addresses only.
    assign w_unused_lsb  = ^{snooper_addr_0[3:0], snooper_addr_1[3:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_wr_sel    = r_wr_vld[0] ? 1'b0 : 1'b1;
        w_rd_sel    = r_rd_vld[0] ? 1'b0 : 1'b1;
`ifdef L2ARB_ROUND_ROBIN_EN
        if (r_wr_vld == 2'b11) w_wr_sel = ~r_last;
        if (r_rd_vld == 2'b11) w_rd_sel = ~r_last;
`endif
        w_wr_done = (r_state == S_WR_ISSUE) && mem_ready;
        w_rd_done = (r_state == S_RD_WAIT) && mem_rdata_valid;
        case (r_state)
            S_IDLE: begin
                if (|r_wr_vld)      w_state_nxt = S_WR_ISSUE;
                else if (|r_rd_vld) w_state_nxt = S_RD_ISSUE;
            end
            S_WR_ISSUE: if (mem_ready)       w_state_nxt = S_IDLE;
            S_RD_ISSUE: if (mem_ready)       w_state_nxt = S_RD_WAIT;
            S_RD_WAIT:  if (mem_rdata_valid) w_state_nxt = S_RESP;
            S_RESP:                          w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_vld    <= '0;
            r_wr_vld    <= '0;
            r_upd_vld   <= '0;
            r_owner     <= 1'b0;
            r_mem_rden  <= 1'b0;
            r_mem_wren  <= 1'b0;
            r_overflow  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef L2ARB_ROUND_ROBIN_EN
            r_last      <= 1'b1;
`endif
            for (int i = 0; i < 2; i++) begin
                r_rd_addr[i] <= '0;
                r_wr_addr[i] <= '0;
                r_wr_dat[i]  <= '0;
                r_upd_dat[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_mem_wren <= (w_state_nxt == S_WR_ISSUE);
            r_mem_rden <= (w_state_nxt == S_RD_ISSUE);
            r_upd_vld  <= '0;

            if (r_state == S_IDLE) begin
                if (|r_wr_vld) begin
                    r_owner     <= w_wr_sel;
                    r_mem_addr  <= {r_wr_addr[w_wr_sel], 4'h0};
                    r_mem_wdata <= r_wr_dat[w_wr_sel];
                end else if (|r_rd_vld) begin
                    r_owner    <= w_rd_sel;
                    r_mem_addr <= {r_rd_addr[w_rd_sel], 4'h0};
                end
            end

            if (w_rd_done) begin
                r_upd_dat[r_owner] <= mem_rdata;
                r_upd_vld[r_owner] <= 1'b1;
            end
`ifdef L2ARB_ROUND_ROBIN_EN
            if (w_wr_done || w_rd_done) r_last <= r_owner;
`endif

            // A slot under service stays occupied until completion, so a same-edge pulse still overflows.
            for (int i = 0; i < 2; i++) begin
                if (w_wr_done && r_owner == 1'(i)) r_wr_vld[i] <= 1'b0;
                if (w_rd_done && r_owner == 1'(i)) r_rd_vld[i] <= 1'b0;
                if (w_rd_req[i]) begin
                    if (r_rd_vld[i]) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_rd_vld[i]  <= 1'b1;
                        r_rd_addr[i] <= w_req_addr[i];
                    end
                end
                if (w_wr_req[i]) begin
                    if (r_wr_vld[i]) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_vld[i]  <= 1'b1;
                        r_wr_addr[i] <= w_req_addr[i];
                        r_wr_dat[i]  <= w_req_dat[i];
                    end
                end
            end
        end
    end

    assign updated_cacheline_0      = r_upd_dat[0];
    assign updated_cacheline_1      = r_upd_dat[1];
    assign cacheline_update_valid_0 = r_upd_vld[0];
    assign cacheline_update_valid_1 = r_upd_vld[1];
    assign mem_addr                 = r_mem_addr;
    assign mem_wdata                = r_mem_wdata;
    assign mem_rden                 = r_mem_rden;
    assign mem_wren                 = r_mem_wren;
    assign overflow                 = r_overflow;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: slot/job-level reference model checked every cycle, plus directed literal checks.
module tb_l2_mem_arbiter;
`ifdef L2ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [31:0]  snooper_addr_0, snooper_addr_1;
    logic         snooper_read_valid_0, snooper_read_valid_1;
    logic         eviction_wren_0, eviction_wren_1;
    logic [127:0] evictable_cacheline_0, evictable_cacheline_1;
    logic [127:0] updated_cacheline_0, updated_cacheline_1;
    logic         cacheline_update_valid_0, cacheline_update_valid_1;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rden, mem_wren;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         mem_rdata_valid;
    logic         overflow;

    l2_mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .snooper_addr_0           (snooper_addr_0),
        .snooper_addr_1           (snooper_addr_1),
        .snooper_read_valid_0     (snooper_read_valid_0),
        .snooper_read_valid_1     (snooper_read_valid_1),
        .eviction_wren_0          (eviction_wren_0),
        .eviction_wren_1          (eviction_wren_1),
        .evictable_cacheline_0    (evictable_cacheline_0),
        .evictable_cacheline_1    (evictable_cacheline_1),
        .updated_cacheline_0      (updated_cacheline_0),
        .updated_cacheline_1      (updated_cacheline_1),
        .cacheline_update_valid_0 (cacheline_update_valid_0),
        .cacheline_update_valid_1 (cacheline_update_valid_1),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_rden                 (mem_rden),
        .mem_wren                 (mem_wren),
        .mem_ready                (mem_ready),
        .mem_rdata                (mem_rdata),
        .mem_rdata_valid          (mem_rdata_valid),
        .overflow                 (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int ram_lat = 1;
    bit force_rv = 1'b0;
    logic [32:0] cmd_log[$];
    int          resp_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM responder: unwritten lines read back as DEAD|addr|0|BEEF.
    logic [127:0] ram [logic [31:0]];
    int           rd_cnt = 0;
    logic [31:0]  rd_addr;

    function automatic logic [127:0] ram_read(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return {16'hDEAD, a, 64'h0, 16'hBEEF};
    endfunction

    always @(posedge clk) begin
        logic        acc_rd, acc_wr;
        logic [31:0] a;
        logic [127:0] d;
        acc_rd = (mem_rden === 1'b1) && mem_ready;
        acc_wr = (mem_wren === 1'b1) && mem_ready;
        a = mem_addr;
        d = mem_wdata;
        #1;
        mem_rdata_valid = 1'b0;
        if (acc_wr) begin
            ram[a] = d;
            cmd_log.push_back({1'b1, a});
        end
        if (acc_rd) begin
            rd_cnt  = ram_lat;
            rd_addr = a;
            cmd_log.push_back({1'b0, a});
        end
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = ram_read(rd_addr);
            end
        end
        if (force_rv) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        end
    end

    // Reference model: pending slots plus at most one job (write, or read before/after acceptance),
    // and a one-cycle response marker that keeps the arbiter from starting a job that cycle.
    logic [1:0]   m_rd_v, m_wr_v;
    logic [31:0]  m_rd_a [2];
    logic [31:0]  m_wr_a [2];
    logic [127:0] m_wr_d [2];
    logic [127:0] m_upd  [2];
    bit           m_job, m_job_wr, m_job_acc, m_ovf, live = 1'b0;
    int           m_port, m_resp, m_last;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;

    function automatic int choose(input logic [1:0] v, input int last);
        if (RR && v == 2'b11) return (last == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        logic [1:0]   ord, owr, prd, pwr;
        logic [31:0]  ia [2];
        logic [127:0] id [2];
        int           p, nresp;
        prd = {snooper_read_valid_1, snooper_read_valid_0};
        pwr = {eviction_wren_1, eviction_wren_0};
        ia[0] = snooper_addr_0;         ia[1] = snooper_addr_1;
        id[0] = evictable_cacheline_0;  id[1] = evictable_cacheline_1;
        if (reset) begin
            m_rd_v = '0; m_wr_v = '0; m_job = 0; m_job_wr = 0; m_job_acc = 0; m_ovf = 0;
            m_port = 0; m_resp = -1; m_last = 1; m_addr = '0; m_wdata = '0;
            for (int i = 0; i < 2; i++) begin
                m_rd_a[i] = '0; m_wr_a[i] = '0; m_wr_d[i] = '0; m_upd[i] = '0;
            end
            live = 1'b1;
        end else if (live) begin
            ord = m_rd_v;
            owr = m_wr_v;
            nresp = -1;
            if (m_job) begin
                if (m_job_wr) begin
                    if (mem_ready) begin
                        m_wr_v[m_port] = 1'b0; m_job = 0; m_last = m_port;
                    end
                end else if (!m_job_acc) begin
                    if (mem_ready) m_job_acc = 1;
                end else if (mem_rdata_valid) begin
                    m_upd[m_port] = mem_rdata; m_rd_v[m_port] = 1'b0;
                    m_job = 0; nresp = m_port; m_last = m_port;
                end
            end else if (m_resp < 0) begin
                if (owr != 2'b00) begin
                    p = choose(owr, m_last);
                    m_job = 1; m_job_wr = 1; m_port = p;
                    m_addr = {m_wr_a[p][31:4], 4'h0};
                    m_wdata = m_wr_d[p];
                end else if (ord != 2'b00) begin
                    p = choose(ord, m_last);
                    m_job = 1; m_job_wr = 0; m_job_acc = 0; m_port = p;
                    m_addr = {m_rd_a[p][31:4], 4'h0};
                end
            end
            m_resp = nresp;
            for (int i = 0; i < 2; i++) begin
                if (prd[i]) begin
                    if (ord[i]) m_ovf = 1;
                    else begin m_rd_v[i] = 1'b1; m_rd_a[i] = ia[i]; end
                end
                if (pwr[i]) begin
                    if (owr[i]) m_ovf = 1;
                    else begin m_wr_v[i] = 1'b1; m_wr_a[i] = ia[i]; m_wr_d[i] = id[i]; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("mem_wren", mem_wren, m_job && m_job_wr);
            chk("mem_rden", mem_rden, m_job && !m_job_wr && !m_job_acc);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("overflow", overflow, m_ovf);
            chk("upd_vld0", cacheline_update_valid_0, m_resp == 0);
            chk("upd_vld1", cacheline_update_valid_1, m_resp == 1);
            chk("upd_dat0", updated_cacheline_0, m_upd[0]);
            chk("upd_dat1", updated_cacheline_1, m_upd[1]);
        end
        if (cacheline_update_valid_0 === 1'b1) resp_log.push_back(0);
        if (cacheline_update_valid_1 === 1'b1) resp_log.push_back(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_resp(input int n, input string name);
        int k = 0;
        while (resp_log.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk({name, "_timeout"}, resp_log.size() >= n, 1);
    endtask

    task automatic clear_req();
        snooper_read_valid_0 = 0; snooper_read_valid_1 = 0;
        eviction_wren_0 = 0; eviction_wren_1 = 0;
    endtask

    initial begin
        reset = 1'b1;
        snooper_addr_0 = '0; snooper_addr_1 = '0;
        clear_req();
        evictable_cacheline_0 = '0; evictable_cacheline_1 = '0;
        mem_ready = 1'b1; mem_rdata = '0; mem_rdata_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        chk("rst_rden", mem_rden, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_upd0", updated_cacheline_0, 0);

        // Single read, latency 3
        ram_lat = 3; cmd_log.delete(); resp_log.delete();
        snooper_addr_0 = 32'h0000_1230; snooper_read_valid_0 = 1; tick();
        clear_req();
        chk("sr_rden_t1", mem_rden, 0);
        tick();
        chk("sr_rden_t2", mem_rden, 1);
        chk("sr_addr_t2", mem_addr, 32'h0000_1230);
        tick(3);
        chk("sr_vld_t5", cacheline_update_valid_0, 0);
        tick();
        chk("sr_vld_t6", cacheline_update_valid_0, 1);
        chk("sr_data_t6", updated_cacheline_0, 128'hDEAD_0000_1230_0000_0000_0000_0000_BEEF);
        chk("sr_other_t6", cacheline_update_valid_1, 0);
        tick();
        chk("sr_vld_t7", cacheline_update_valid_0, 0);

        // Eviction-first ordering on the same line
        ram_lat = 1; cmd_log.delete(); resp_log.delete();
        snooper_addr_1 = 32'h40; snooper_read_valid_1 = 1;
        snooper_addr_0 = 32'h40; eviction_wren_0 = 1; evictable_cacheline_0 = {16{8'hA5}};
        tick();
        clear_req();
        wait_resp(1, "ef");
        tick();
        chk("ef_ncmd", cmd_log.size(), 2);
        chk("ef_cmd0", cmd_log[0], {1'b1, 32'h40});
        chk("ef_cmd1", cmd_log[1], {1'b0, 32'h40});
        chk("ef_owner", resp_log[0], 1);
        chk("ef_data", updated_cacheline_1, {16{8'hA5}});

        // Simultaneous reads from both ports
        do_reset();
        resp_log.delete();
        for (int r = 0; r < 2; r++) begin
            snooper_addr_0 = 32'h100 + 32'(r * 16); snooper_read_valid_0 = 1;
            snooper_addr_1 = 32'h200 + 32'(r * 16); snooper_read_valid_1 = 1;
            tick();
            clear_req();
            wait_resp(2 * (r + 1), "sim");
            tick(2);
        end
        chk("sim_ord0", resp_log[0], 0);
        chk("sim_ord1", resp_log[1], 1);
        chk("sim_ord2", resp_log[2], 0);
        chk("sim_ord3", resp_log[3], 1);
        snooper_addr_0 = 32'h300; eviction_wren_0 = 1; evictable_cacheline_0 = 128'h1;
        tick();
        clear_req();
        tick(4);
        resp_log.delete();
        snooper_addr_0 = 32'h110; snooper_read_valid_0 = 1;
        snooper_addr_1 = 32'h210; snooper_read_valid_1 = 1;
        tick();
        clear_req();
        wait_resp(2, "sim_after_wr");
        chk("sim_after_wr_first", resp_log[0], RR ? 1 : 0);
        tick(3);

        // Overflow on the port-1 read slot
        do_reset();
        ram_lat = 2; cmd_log.delete(); resp_log.delete();
        snooper_addr_1 = 32'h500; snooper_read_valid_1 = 1; tick();
        snooper_addr_1 = 32'h600;
        chk("ovf_t1", overflow, 0);
        tick();
        clear_req();
        chk("ovf_t2", overflow, 1);
        wait_resp(1, "ovf");
        tick(4);
        chk("ovf_ncmd", cmd_log.size(), 1);
        chk("ovf_addr", cmd_log[0], {1'b0, 32'h500});
        chk("ovf_sticky", overflow, 1);

        // Write backpressure: mem_ready low for 5 strobe cycles
        do_reset();
        cmd_log.delete(); resp_log.delete();
        mem_ready = 1'b0;
        snooper_addr_1 = 32'h700; eviction_wren_1 = 1;
        evictable_cacheline_1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tick();
        clear_req();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_wren", mem_wren, 1);
            chk("bp_addr", mem_addr, 32'h700);
            chk("bp_wdata", mem_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
            if (k == 2) begin
                snooper_addr_1 = 32'h7F0; eviction_wren_1 = 1; evictable_cacheline_1 = '1;
            end else begin
                eviction_wren_1 = 0;
            end
            tick();
        end
        chk("bp_ovf", overflow, 1);
        chk("bp_still_wren", mem_wren, 1);
        mem_ready = 1'b1;
        tick();
        chk("bp_released", mem_wren, 0);
        snooper_addr_1 = 32'h710; eviction_wren_1 = 1; evictable_cacheline_1 = 128'h77;
        tick();
        clear_req();
        tick(5);
        chk("bp_ncmd", cmd_log.size(), 2);
        chk("bp_cmd0", cmd_log[0], {1'b1, 32'h700});
        chk("bp_cmd1", cmd_log[1], {1'b1, 32'h710});

        // Reset while waiting for read data; late data must be ignored
        ram_lat = 6; resp_log.delete();
        snooper_addr_0 = 32'h800; snooper_read_valid_0 = 1; tick();
        clear_req();
        tick(3);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rmr_rden", mem_rden, 0);
        chk("rmr_addr", mem_addr, 0);
        chk("rmr_wdata", mem_wdata, 0);
        chk("rmr_ovf", overflow, 0);
        chk("rmr_upd0", updated_cacheline_0, 0);
        chk("rmr_upd1", updated_cacheline_1, 0);
        force_rv = 1'b1; tick(2); force_rv = 1'b0;
        tick(10);
        chk("rmr_no_resp", resp_log.size(), 0);
        chk("rmr_upd0_late", updated_cacheline_0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
